// File: rtl/alu_result_queue.sv
// Result queue between the ALU and register-file writeback: show-ahead FIFO of
// {data, flags, dest} entries with a branch-condition test on the head entry.
module alu_result_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [3:0]        InFlags,
  input  logic [2:0]        InDest,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [3:0]        OutFlags,
  output logic [2:0]        OutDest,
  input  logic [3:0]        CondSel,
  output logic              CondTrue,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overrun,
  input  logic              ClrErr
);

  localparam int ENTRY_W = DATA_W + 7;

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]    count_reg, count_next;
  logic               overrun_reg, overrun_next;
  logic               full, empty, push, pop, cond_hit;
  logic [ENTRY_W-1:0] head;

  assign full  = (count_reg == (ADDR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = InValid & ~full;
  assign pop   = OutReady & ~empty;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    if (Flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
        2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
        default: count_next = count_reg;
      endcase
    end
    // A rejected write while full outranks a same-cycle clear request.
    if (InValid && full)
      overrun_next = 1'b1;
    else if (ClrErr)
      overrun_next = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  // Storage is reset so an entry read before its first write shows zero, not X.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
          mem_reg[gi] <= '0;
        else if (push && !Flush && wr_ptr_reg == ADDR_W'(gi))
          mem_reg[gi] <= {InData, InFlags, InDest};
      end
    end
  endgenerate

  assign head = mem_reg[rd_ptr_reg];

  // Flags are packed {Z, C, N, O} from bit 3 down to bit 0.
  always_comb begin
    cond_hit = 1'b0;
    case (CondSel)
      4'd0:    cond_hit = 1'b1;
      4'd1:    cond_hit = OutFlags[3];
      4'd2:    cond_hit = ~OutFlags[3];
      4'd3:    cond_hit = OutFlags[2];
      4'd4:    cond_hit = ~OutFlags[2];
      4'd5:    cond_hit = OutFlags[1];
      4'd6:    cond_hit = ~OutFlags[1];
      4'd7:    cond_hit = OutFlags[0];
      4'd8:    cond_hit = ~OutFlags[0];
      4'd9:    cond_hit = OutFlags[2] & ~OutFlags[3];
      4'd10:   cond_hit = (OutFlags[1] == OutFlags[0]);
      4'd11:   cond_hit = (OutFlags[1] != OutFlags[0]);
      default: cond_hit = 1'b0;
    endcase
  end

  assign OutData  = head[ENTRY_W-1 -: DATA_W];
  assign OutFlags = head[6:3];
  assign OutDest  = head[2:0];
  assign OutValid = ~empty;
  assign InReady  = ~full;
  assign CondTrue = cond_hit & ~empty;
  assign Count    = count_reg;
  assign Full     = full;
  assign Empty    = empty;
  assign Overrun  = overrun_reg;

endmodule
